// File: rtl/fp_mac_unit.sv
// fp_mac_unit: multi-cycle floating-point multiply / multiply-accumulate.
// Truncating arithmetic, exp==0 operands are zero, exp==all-ones operands are infinity.
module fp_mac_unit #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 acc_clr,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] P,
  output logic                 ready,
  output logic                 busy
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW1 = MAN_W + 1;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MW1;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX_S = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ALIGN = 3'd3,
    S_ADD   = 3'd4,
    S_RNORM = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Pack sign/exponent/mantissa, saturating to infinity or flushing to zero.
  function automatic logic [W-1:0] pack_fp(input logic s, input logic signed [EW2-1:0] e,
                                           input logic [MW1-1:0] m);
    logic [W-1:0] r;
    if (e >= EMAX_S)   r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e < ONE_S) r = {s, {(W-1){1'b0}}};
    else               r = {s, e[EXP_W-1:0], m[MAN_W-1:0]};
    return r;
  endfunction

  // Leading-zero count of a hidden-bit-wide mantissa.
  function automatic int lzc(input logic [MW1-1:0] v);
    int   n;
    logic found;
    n = 0;
    found = 1'b0;
    for (int i = MW1 - 1; i >= 0; i--) begin
      if (!found && v[i]) found = 1'b1;
      else if (!found)    n = n + 1;
    end
    return n;
  endfunction

  state_t                 state_q;
  logic                   mode_q, clr_q;
  logic [W-1:0]           a_q, b_q, prod_q, acc_q, p_q;
  logic                   psign_q, pzero_q, pinf_q;
  logic signed [EW2-1:0]  pexp_q, rexp_q;
  logic [PW-1:0]          pman_q;
  logic                   x_sign_q, y_sign_q, rinf_q, rinf_sign_q, ssign_q;
  logic [MW1-1:0]         x_man_q, y_man_q;
  logic [MW1:0]           sum_q;
  logic                   ready_q, busy_q;

  logic                   mul_sign, mul_zero, mul_inf;
  logic signed [EW2-1:0]  mul_exp, nrm_exp, rn_exp;
  logic [PW-1:0]          mul_man;
  logic [MW1-1:0]         nrm_man, rn_man;
  logic [W-1:0]           nrm_word, rn_word, addend;
  logic [EXP_W-1:0]       pe, qe, big_exp, diff;
  logic [MW1-1:0]         pm, qm, big_man, sml_man, sml_shift;
  logic                   big_sign, sml_sign, p_inf, q_inf, aln_inf, aln_inf_sign;
  logic [MW1:0]           add_sum;
  logic                   add_sign;
  int                     lz;

  // MUL stage: sign, biased exponent sum and full mantissa product.
  always_comb begin
    mul_sign = a_q[W-1] ^ b_q[W-1];
    mul_exp  = EW2'(a_q[W-2:MAN_W]) + EW2'(b_q[W-2:MAN_W]) - BIAS_S;
    mul_man  = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
    mul_zero = (a_q[W-2:MAN_W] == '0) || (b_q[W-2:MAN_W] == '0);
    mul_inf  = (a_q[W-2:MAN_W] == '1) || (b_q[W-2:MAN_W] == '1);
  end

  // NORM stage: one-bit normalise, truncate, apply special cases.
  always_comb begin
    if (pman_q[PW-1]) begin
      nrm_man = pman_q[PW-1 -: MW1];
      nrm_exp = pexp_q + ONE_S;
    end else begin
      nrm_man = pman_q[PW-2 -: MW1];
      nrm_exp = pexp_q;
    end
    if (pzero_q)     nrm_word = {psign_q, {(W-1){1'b0}}};
    else if (pinf_q) nrm_word = {psign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else             nrm_word = pack_fp(psign_q, nrm_exp, nrm_man);
  end

  // ALIGN stage: order by exponent and shift the smaller operand right.
  always_comb begin
    addend = clr_q ? '0 : acc_q;
    pe     = prod_q[W-2:MAN_W];
    qe     = addend[W-2:MAN_W];
    pm     = (pe == '0) ? '0 : {1'b1, prod_q[MAN_W-1:0]};
    qm     = (qe == '0) ? '0 : {1'b1, addend[MAN_W-1:0]};
    if (pe >= qe) begin
      big_sign = prod_q[W-1]; big_man = pm; big_exp = pe;
      sml_sign = addend[W-1]; sml_man = qm; diff = pe - qe;
    end else begin
      big_sign = addend[W-1]; big_man = qm; big_exp = qe;
      sml_sign = prod_q[W-1]; sml_man = pm; diff = qe - pe;
    end
    if (int'(diff) >= MAN_W + 2) sml_shift = '0;
    else                         sml_shift = sml_man >> diff;
    p_inf = (pe == '1);
    q_inf = (qe == '1);
    aln_inf = p_inf | q_inf;
    // Opposite infinities resolve to +inf.
    if (p_inf && q_inf) aln_inf_sign = prod_q[W-1] & addend[W-1];
    else if (p_inf)     aln_inf_sign = prod_q[W-1];
    else                aln_inf_sign = addend[W-1];
  end

  // ADD stage: signed-magnitude add, larger magnitude sets the sign.
  always_comb begin
    if (x_sign_q == y_sign_q) begin
      add_sum  = {1'b0, x_man_q} + {1'b0, y_man_q};
      add_sign = x_sign_q;
    end else if (x_man_q >= y_man_q) begin
      add_sum  = {1'b0, x_man_q - y_man_q};
      add_sign = x_sign_q;
    end else begin
      add_sum  = {1'b0, y_man_q - x_man_q};
      add_sign = y_sign_q;
    end
  end

  // RNORM stage: renormalise the sum and handle infinity / exact zero.
  always_comb begin
    lz     = lzc(sum_q[MAN_W:0]);
    rn_man = sum_q[MAN_W:0];
    rn_exp = rexp_q;
    if (rinf_q) begin
      rn_word = {rinf_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (sum_q == '0) begin
      rn_word = '0;
    end else if (sum_q[MW1]) begin
      rn_man  = sum_q[MW1:1];
      rn_exp  = rexp_q + ONE_S;
      rn_word = pack_fp(ssign_q, rn_exp, rn_man);
    end else begin
      rn_man  = sum_q[MAN_W:0] << lz;
      rn_exp  = rexp_q - EW2'(lz);
      rn_word = pack_fp(ssign_q, rn_exp, rn_man);
    end
  end

  // Control FSM with stage registers, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= 1'b0; clr_q <= 1'b0;
      a_q <= '0; b_q <= '0; prod_q <= '0; acc_q <= '0; p_q <= '0;
      psign_q <= 1'b0; pzero_q <= 1'b0; pinf_q <= 1'b0;
      pexp_q <= '0; pman_q <= '0; rexp_q <= '0;
      x_sign_q <= 1'b0; y_sign_q <= 1'b0; x_man_q <= '0; y_man_q <= '0;
      rinf_q <= 1'b0; rinf_sign_q <= 1'b0; sum_q <= '0; ssign_q <= 1'b0;
      ready_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (start) begin
            a_q <= a; b_q <= b; mode_q <= mode; clr_q <= acc_clr;
            busy_q <= 1'b1;
            state_q <= S_MUL;
          end else if (acc_clr) begin
            acc_q <= '0;
          end
        end
        S_MUL: begin
          psign_q <= mul_sign; pexp_q <= mul_exp; pman_q <= mul_man;
          pzero_q <= mul_zero; pinf_q <= mul_inf;
          state_q <= S_NORM;
        end
        S_NORM: begin
          prod_q <= nrm_word;
          if (mode_q) begin
            state_q <= S_ALIGN;
          end else begin
            p_q <= nrm_word;
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_ALIGN: begin
          x_sign_q <= big_sign; x_man_q <= big_man;
          y_sign_q <= sml_sign; y_man_q <= sml_shift;
          rexp_q <= EW2'(big_exp);
          rinf_q <= aln_inf; rinf_sign_q <= aln_inf_sign;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q <= add_sum; ssign_q <= add_sign;
          state_q <= S_RNORM;
        end
        S_RNORM: begin
          p_q <= rn_word;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (mode_q) acc_q <= p_q;
          ready_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign P     = p_q;
  assign ready = ready_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_fp_mac_unit.sv
// tb_fp_mac_unit: directed and random checks of fp_mac_unit (FP16) against a value-level model.
module tb_fp_mac_unit;
  logic        clk = 1'b0;
  logic        reset, start, mode, acc_clr;
  logic [15:0] a, b, P;
  logic        ready, busy;
  int          total = 0;
  int          bad = 0;

  fp_mac_unit #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .acc_clr(acc_clr),
    .a(a), .b(b), .P(P), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Round a value mag * 2^k toward zero into FP16.
  function automatic logic [15:0] pack_ref(input bit s, input longint mag, input int k);
    int p, be;
    longint m;
    logic [4:0] e5;
    logic [9:0] m10;
    if (mag == 0) return {s, 15'h0000};
    p = 0;
    for (int i = 0; i < 48; i++) if (((mag >> i) & 64'sd1) != 0) p = i;
    be = p + k + 15;
    if (p >= 10) m = mag >> (p - 10);
    else         m = mag << (10 - p);
    if (be >= 31) return {s, 5'h1F, 10'h000};
    if (be <= 0)  return {s, 15'h0000};
    e5 = be[4:0];
    m10 = m[9:0];
    return {s, e5, m10};
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    bit s;
    int ex, ey;
    longint mx, my;
    s = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    if (ex == 0 || ey == 0)  return {s, 15'h0000};
    if (ex == 31 || ey == 31) return {s, 5'h1F, 10'h000};
    mx = 1024 + int'(x[9:0]);
    my = 1024 + int'(y[9:0]);
    return pack_ref(s, mx * my, ex + ey - 30 - 20);
  endfunction

  // Sum on the grid of the larger exponent: smaller operand truncated to that grid.
  function automatic logic [15:0] ref_add(input logic [15:0] p, input logic [15:0] q);
    bit pi, qi;
    int ep, eq, eb;
    longint mp, mq, s;
    ep = int'(p[14:10]);
    eq = int'(q[14:10]);
    pi = (ep == 31);
    qi = (eq == 31);
    if (pi && qi) return {p[15] & q[15], 5'h1F, 10'h000};
    if (pi)       return {p[15], 5'h1F, 10'h000};
    if (qi)       return {q[15], 5'h1F, 10'h000};
    mp = (ep == 0) ? 0 : 1024 + int'(p[9:0]);
    mq = (eq == 0) ? 0 : 1024 + int'(q[9:0]);
    eb = (ep > eq) ? ep : eq;
    mp = mp >> (eb - ep);
    mq = mq >> (eb - eq);
    s = (p[15] ? -mp : mp) + (q[15] ? -mq : mq);
    if (s == 0) return 16'h0000;
    return pack_ref(s < 0, (s < 0) ? -s : s, eb - 25);
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    logic [9:0] m;
    m = 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 9) == 0)      e = 5'd0;
    else if ($urandom_range(0, 3) == 0) e = 5'($urandom_range(1, 30));
    else                                e = 5'($urandom_range(8, 22));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // One operation from a negedge; returns P and the edge count from start to ready.
  task automatic run_op(input logic m, input logic c, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] res, output int lat);
    start = 1'b1; mode = m; acc_clr = c; a = x; b = y;
    @(posedge clk); #1;
    check("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      a = 16'($urandom); b = 16'($urandom); mode = ~m; acc_clr = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    acc_clr = 1'b0; mode = 1'b0; a = 16'h0; b = 16'h0;
    res = P;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Observe ACC through a MAC with a zero product.
  task automatic peek_acc(output logic [15:0] res);
    int lat;
    run_op(1'b1, 1'b0, 16'h0000, 16'h3C00, res, lat);
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] r, e, pr, x, y, acc_m;
    logic        m, c;
    int          lat, cnt, first, last;

    reset = 1'b1; start = 1'b0; mode = 1'b0; acc_clr = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_P", 32'(P), 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 1'b0, 16'h4400, 16'h4600, r, lat);
    check("mul_P", 32'(r), 32'h4E00);
    check("mul_lat", 32'(lat), 32'd2);
    peek_acc(r);
    check("mul_acc_untouched", 32'(r), 32'h0000);
    run_op(1'b0, 1'b0, 16'h4000, 16'hC400, r, lat);
    check("signed_mul_P", 32'(r), 32'hC800);

    run_op(1'b1, 1'b1, 16'h4400, 16'h4600, r, lat);
    check("mac1_P", 32'(r), 32'h4E00);
    check("mac1_lat", 32'(lat), 32'd5);
    run_op(1'b1, 1'b0, 16'h4000, 16'hC400, r, lat);
    check("mac2_P", 32'(r), 32'h4C00);
    peek_acc(r);
    check("mac2_acc", 32'(r), 32'h4C00);
    run_op(1'b0, 1'b0, 16'h4000, 16'h4000, r, lat);
    check("mul_4", 32'(r), 32'h4400);
    peek_acc(r);
    check("acc_kept_by_mul", 32'(r), 32'h4C00);

    run_op(1'b0, 1'b0, 16'h0000, 16'h4600, r, lat);
    check("zero_mul", 32'(r), 32'h0000);
    run_op(1'b0, 1'b0, 16'h8000, 16'h4600, r, lat);
    check("neg_zero_mul", 32'(r), 32'h8000);
    run_op(1'b0, 1'b0, 16'h7BFF, 16'h7BFF, r, lat);
    check("overflow_mul", 32'(r), 32'h7C00);
    run_op(1'b0, 1'b0, 16'h0400, 16'h0400, r, lat);
    check("underflow_mul", 32'(r), 32'h0000);
    run_op(1'b0, 1'b0, 16'h7C00, 16'hC000, r, lat);
    check("inf_mul", 32'(r), 32'hFC00);
    run_op(1'b1, 1'b1, 16'h4400, 16'h4600, r, lat);
    run_op(1'b1, 1'b0, 16'hC400, 16'h4600, r, lat);
    check("mac_cancel", 32'(r), 32'h0000);
    run_op(1'b1, 1'b1, 16'h7C00, 16'h3C00, r, lat);
    check("mac_pinf", 32'(r), 32'h7C00);
    run_op(1'b1, 1'b0, 16'hFC00, 16'h3C00, r, lat);
    check("mac_inf_cancel", 32'(r), 32'h7C00);

    run_op(1'b1, 1'b1, 16'h4400, 16'h4600, r, lat);
    pulse_clr();
    peek_acc(r);
    check("acc_clr_alone", 32'(r), 32'h0000);

    // start held high, mode 0: one op per 4 cycles
    start = 1'b1; mode = 1'b0; a = 16'h4000; b = 16'h4200;
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin cnt++; if (first < 0) first = i; last = i; end
    end
    start = 1'b0;
    check("held_m0_count", 32'(cnt), 32'd5);
    check("held_m0_first", 32'(first), 32'd2);
    check("held_m0_last", 32'(last), 32'd18);
    check("held_m0_P", 32'(P), 32'(ref_mul(16'h4000, 16'h4200)));
    @(negedge clk);

    // start and acc_clr held high, mode 1: one op per 7 cycles
    start = 1'b1; mode = 1'b1; acc_clr = 1'b1; a = 16'h4200; b = 16'h4500;
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (ready) begin cnt++; if (first < 0) first = i; last = i; end
    end
    start = 1'b0; acc_clr = 1'b0;
    check("held_m1_count", 32'(cnt), 32'd3);
    check("held_m1_first", 32'(first), 32'd5);
    check("held_m1_last", 32'(last), 32'd19);
    check("held_m1_P", 32'(P), 32'h4B80);
    @(negedge clk);

    // start pulse landing in DONE is dropped
    start = 1'b1; mode = 1'b0; a = 16'h4400; b = 16'h4400;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ready) cnt++;
      start = (i == 2) ? 1'b1 : 1'b0;
    end
    check("start_in_done_dropped", 32'(cnt), 32'd1);
    check("single_op_P", 32'(P), 32'h4C00);
    @(negedge clk);

    // reset in cycle 3 of a MAC
    run_op(1'b1, 1'b1, 16'h4400, 16'h4600, r, lat);
    start = 1'b1; mode = 1'b1; a = 16'h4000; b = 16'h4000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_P", 32'(P), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready || busy) cnt++;
    end
    check("midrst_quiet", 32'(cnt), 32'd0);
    @(negedge clk);
    peek_acc(r);
    check("midrst_acc", 32'(r), 32'h0000);
    run_op(1'b0, 1'b0, 16'h4000, 16'hC400, r, lat);
    check("after_rst_P", 32'(r), 32'hC800);
    check("after_rst_lat", 32'(lat), 32'd2);

    // random operations against the model
    pulse_clr();
    acc_m = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 5) == 0);
      x = rand_op();
      y = rand_op();
      pr = ref_mul(x, y);
      if (m) begin
        e = ref_add(pr, c ? 16'h0000 : acc_m);
        acc_m = e;
      end else begin
        e = pr;
      end
      run_op(m, c, x, y, r, lat);
      check($sformatf("rand%0d_P a=%h b=%h mode=%0d clr=%0d", i, x, y, m, c), 32'(r), 32'(e));
      check($sformatf("rand%0d_lat", i), 32'(lat), m ? 32'd5 : 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
